// File: rtl/fp_acc_stream_pkg.sv
// Shared types for the fp_acc_stream reduction block: zero word, FSM states and the
// adder lane tag that travels alongside each in-flight addition.
package fp_pkg;

  localparam int unsigned FP_W   = 16;
  localparam int unsigned LANE_W = 4;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    COMBINE,
    OUTPUT
  } acc_state_t;

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
  } lane_tag_t;

endpackage

// File: rtl/fp_acc_stream_if.sv
// Input stream, output stream and external fp_add issue/return signals of fp_acc_stream.
// out_count exists only when FP_ACC_COUNT_EN is defined.
interface fp_acc_stream_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  logic             add_valid;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_result_valid;
  logic [WIDTH-1:0] add_result;

`ifdef FP_ACC_COUNT_EN
  logic [15:0]      out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, add_result_valid, add_result,
    output in_ready, out_valid, out_data, add_valid, add_a, add_b, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, add_result_valid, add_result,
    input  in_ready, out_valid, out_data, add_valid, add_a, add_b, out_count
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready, add_result_valid, add_result,
    output in_ready, out_valid, out_data, add_valid, add_a, add_b
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, add_result_valid, add_result,
    input  in_ready, out_valid, out_data, add_valid, add_a, add_b
  );
`endif

endinterface

// File: rtl/fp_acc_stream_tag_pipe.sv
// DEPTH-deep shift register of lane tags that tracks additions in flight in the adder.
// o_empty: nothing left in flight once the tag at the output retires this cycle.
module fp_tag_pipe
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clock,
  input  logic      clock_sreset,
  input  lane_tag_t i_tag,
  output lane_tag_t o_tag,
  output logic      o_empty
);

  lane_tag_t r_stage [DEPTH];

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    o_empty = ~i_tag.valid;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      if (r_stage[i].valid) o_empty = 1'b0;
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/fp_acc_stream.sv
// Packet sum over an external fp_add using ADD_LATENCY interleaved partial-sum lanes.
// Optional FP_ACC_COUNT_EN adds a saturating word count reported with the sum.
module fp_acc_stream
  import fp_pkg::*;
#(
  parameter int unsigned EXP         = 8,
  parameter int unsigned MANT        = 7,
  parameter int unsigned WIDTH       = EXP + MANT + 1,
  parameter int unsigned ADD_LATENCY = 2
) (
  input  logic            clock,
  input  logic            clock_sreset,
  fp_acc_stream_if.slave  bus
);

  acc_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_psum [ADD_LATENCY];
  logic [WIDTH-1:0] r_acc;
  logic [LANE_W-1:0] r_ptr, r_k, w_ptr_nxt;
  logic             r_wait;

  lane_tag_t        w_tag_in, w_tag_out;
  logic             w_pipe_empty;
  logic             w_in_xfer, w_out_xfer, w_wb, w_bypass;
  logic [WIDTH-1:0] w_psum_ptr, w_psum_k, w_lane0_live;

  logic             w_in_ready, w_out_valid, w_add_valid;
  logic [WIDTH-1:0] w_add_a, w_add_b;

  assign w_in_xfer  = bus.in_valid & (r_state == ACCUM);
  assign w_out_xfer = (r_state == OUTPUT) & bus.out_ready;
  assign w_wb       = bus.add_result_valid & w_tag_out.valid;
  assign w_bypass   = w_wb & (w_tag_out.lane == r_ptr);
  assign w_ptr_nxt  = (r_ptr == LANE_W'(ADD_LATENCY - 1)) ? '0 : r_ptr + LANE_W'(1);

  assign w_tag_in.valid = w_in_xfer;
  assign w_tag_in.lane  = r_ptr;

  fp_tag_pipe #(
    .DEPTH (ADD_LATENCY)
  ) u_tag_pipe (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .i_tag        (w_tag_in),
    .o_tag        (w_tag_out),
    .o_empty      (w_pipe_empty)
  );

  always_comb begin
    w_psum_ptr = '0;
    w_psum_k   = '0;
    for (int unsigned i = 0; i < ADD_LATENCY; i++) begin
      if (r_ptr == LANE_W'(i)) w_psum_ptr = r_psum[i];
      if (r_k == LANE_W'(i))   w_psum_k   = r_psum[i];
    end
  end

  // Lane 0 may be written back on the very edge DRAIN exits, so forward it into acc.
  assign w_lane0_live = (w_wb && w_tag_out.lane == '0) ? bus.add_result : r_psum[0];

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) r_state <= ACCUM;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_add_valid = 1'b0;
    w_add_a     = '0;
    w_add_b     = '0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_add_valid = 1'b1;
          w_add_a     = bus.in_data;
          w_add_b     = w_bypass ? bus.add_result : w_psum_ptr;
          if (bus.in_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pipe_empty) w_state_nxt = (ADD_LATENCY == 1) ? OUTPUT : COMBINE;
      end
      COMBINE: begin
        if (!r_wait) begin
          w_add_valid = 1'b1;
          w_add_a     = r_acc;
          w_add_b     = w_psum_k;
        end else if (bus.add_result_valid && r_k == LANE_W'(ADD_LATENCY - 1)) begin
          w_state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      for (int unsigned i = 0; i < ADD_LATENCY; i++) r_psum[i] <= WIDTH'(FP_ZERO);
      r_ptr <= '0;
    end else if (w_out_xfer) begin
      for (int unsigned i = 0; i < ADD_LATENCY; i++) r_psum[i] <= WIDTH'(FP_ZERO);
      r_ptr <= '0;
    end else begin
      if (w_wb) begin
        for (int unsigned i = 0; i < ADD_LATENCY; i++) begin
          if (w_tag_out.lane == LANE_W'(i)) r_psum[i] <= bus.add_result;
        end
      end
      if (w_in_xfer) r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      r_acc  <= WIDTH'(FP_ZERO);
      r_k    <= '0;
      r_wait <= 1'b0;
    end else begin
      case (r_state)
        DRAIN: begin
          if (w_pipe_empty) begin
            r_acc  <= w_lane0_live;
            r_k    <= LANE_W'(1);
            r_wait <= 1'b0;
          end
        end
        COMBINE: begin
          if (!r_wait) begin
            r_wait <= 1'b1;
          end else if (bus.add_result_valid) begin
            r_acc  <= bus.add_result;
            r_k    <= r_k + LANE_W'(1);
            r_wait <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_ACC_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset)                     r_count <= '0;
    else if (w_out_xfer)                  r_count <= '0;
    else if (w_in_xfer && r_count != '1)  r_count <= r_count + 16'd1;
  end

  assign bus.out_count = r_count;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.add_valid = w_add_valid;
  assign bus.add_a     = w_add_a;
  assign bus.add_b     = w_add_b;

endmodule

// File: tb/tb_fp_acc_stream.sv
// Directed bench for fp_acc_stream with a 2-cycle bf16 adder model (EXP=8, MANT=7).
module tb_fp_acc_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_acc_stream_if #(.WIDTH(16)) bus ();

  fp_acc_stream #(
    .EXP         (8),
    .MANT        (7),
    .WIDTH       (16),
    .ADD_LATENCY (2)
  ) dut (
    .clock        (clk),
    .clock_sreset (rst),
    .bus          (bus)
  );

  function automatic real bf2r(input logic [15:0] x);
    real v;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(x[6:0]) / 128.0;
    e = int'(x[14:7]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2bf(input real v);
    logic s;
    int   e;
    int   m;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    if (s) v = -v;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 128.0);
    return {s, e[7:0], m[6:0]};
  endfunction

  // Attached adder: two stages, deliberately not reset so stale results survive a DUT reset.
  logic        a_v1 = 1'b0, a_v2 = 1'b0;
  logic [15:0] a_r1 = '0,   a_r2 = '0;
  always @(posedge clk) begin
    a_v1 <= bus.add_valid;
    a_r1 <= r2bf(bf2r(bus.add_a) + bf2r(bus.add_b));
    a_v2 <= a_v1;
    a_r2 <= a_r1;
  end
  assign bus.add_result_valid = a_v2;
  assign bus.add_result       = a_r2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word from a negedge; it is accepted on the following posedge.
  task automatic drive(input string tag, input logic [15:0] d, input logic l,
                       input logic [15:0] exp_b);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
    check({tag, ".in_ready"},  16'(bus.in_ready), 16'h1);
    check({tag, ".add_valid"}, 16'(bus.add_valid), 16'h1);
    check({tag, ".add_a"},     bus.add_a, d);
    check({tag, ".add_b"},     bus.add_b, exp_b);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Called at the negedge one cycle after the last word was accepted.
  task automatic expect_sum(input string tag, input logic [15:0] exp_d, input int hold,
                            input logic [15:0] exp_cnt);
    int   n;
    logic rdy_seen;
    n        = 1;
    rdy_seen = bus.in_ready;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
      rdy_seen = rdy_seen | bus.in_ready;
    end
    check({tag, ".latency"},     16'(n), 16'd6);
    check({tag, ".in_ready_low"}, 16'(rdy_seen), 16'h0);
    check({tag, ".out_data"},    bus.out_data, exp_d);
`ifdef FP_ACC_COUNT_EN
    check({tag, ".out_count"},   bus.out_count, exp_cnt);
`else
    if (exp_cnt == 16'hFFFF) $display("note: unexpected count request in %s", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 16'(bus.out_valid), 16'h1);
      check({tag, ".hold_data"},  bus.out_data, exp_d);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 16'(bus.out_valid), 16'h0);
    check({tag, ".in_ready_back"},  16'(bus.in_ready), 16'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("rst.in_ready",  16'(bus.in_ready), 16'h1);
    check("rst.out_valid", 16'(bus.out_valid), 16'h0);
    check("rst.out_data",  bus.out_data, 16'h0000);
    check("rst.add_valid", 16'(bus.add_valid), 16'h0);
    check("rst.add_a",     bus.add_a, 16'h0000);
    check("rst.add_b",     bus.add_b, 16'h0000);
`ifdef FP_ACC_COUNT_EN
    check("rst.out_count", bus.out_count, 16'h0000);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1+2+3+4 back-to-back; words 3 and 4 pick up their lane's sum through the bypass
    drive("s1.w0", 16'h3F80, 1'b0, 16'h0000);
    drive("s1.w1", 16'h4000, 1'b0, 16'h0000);
    drive("s1.w2", 16'h4040, 1'b0, 16'h3F80);
    drive("s1.w3", 16'h4080, 1'b1, 16'h4000);
    expect_sum("s1", 16'h4120, 0, 16'd4);

    drive("s2.w0", 16'h4040, 1'b1, 16'h0000);
    expect_sum("s2", 16'h4040, 0, 16'd1);

    // Same packet with idle gaps: lanes rotate only on transfers, operands come from storage
    drive("s3.w0", 16'h3F80, 1'b0, 16'h0000);
    @(negedge clk);
    drive("s3.w1", 16'h4000, 1'b0, 16'h0000);
    @(negedge clk);
    drive("s3.w2", 16'h4040, 1'b0, 16'h3F80);
    @(negedge clk);
    drive("s3.w3", 16'h4080, 1'b1, 16'h4000);
    expect_sum("s3", 16'h4120, 0, 16'd4);

    drive("s4.w0", 16'h3F80, 1'b0, 16'h0000);
    drive("s4.w1", 16'h4000, 1'b0, 16'h0000);
    drive("s4.w2", 16'h4040, 1'b0, 16'h3F80);
    drive("s4.w3", 16'h4080, 1'b1, 16'h4000);
    expect_sum("s4", 16'h4120, 5, 16'd4);

    // Reset mid-packet while both adds are still inside the adder
    drive("s5.w0", 16'h3F80, 1'b0, 16'h0000);
    drive("s5.w1", 16'h4000, 1'b0, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    check("s5.rst_out_valid", 16'(bus.out_valid), 16'h0);
    check("s5.rst_in_ready",  16'(bus.in_ready), 16'h1);
    check("s5.rst_out_data",  bus.out_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    drive("s5.w2", 16'h3F80, 1'b1, 16'h0000);
    expect_sum("s5", 16'h3F80, 0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_acc_stream.md
Name: fp_acc_stream

Overview:
- Stream-reduction controller: accepts a packet of floating-point values (one per handshake, terminated by in_last) and emits their sum.
- Acts as the initiator for an external fp_add pipeline. It drives add_valid/add_a/add_b and consumes add_result_valid/add_result.
- Hides adder latency by interleaving ADD_LATENCY partial-sum lanes, then folds the lanes into one result.
- Sits between conv/MAC output streams and the activation/writeback path.

Parameters:
EXP, 8, exponent width
MANT, 7, stored mantissa width
WIDTH, EXP+MANT+1, word width (sign, exponent, mantissa)
ADD_LATENCY, 2, cycles from add_valid to add_result_valid of the attached adder (>=1)

Ports:
clock  in  1  clock
clock_sreset  in  1  asynchronous active-high reset (name kept per codebase)
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
in_data  in  WIDTH  input operand
in_last  in  1  final word of packet
out_valid  out  1  sum valid, held until accepted
out_ready  in  1  downstream accepts sum
out_data  out  WIDTH  packet sum
add_valid  out  1  issue to adder
add_a  out  WIDTH  adder operand a
add_b  out  WIDTH  adder operand b
add_result_valid  in  1  adder result valid
add_result  in  WIDTH  adder result

Behaviour:
- Clock and reset: one clock, clock. clock_sreset is asynchronous, active-high.
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_data=0, add_valid=0, add_a=0, add_b=0, all psum lanes=0, lane pointer=0, tag pipeline empty.
- Zero is all-zero bits.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- States: ACCUM, DRAIN, COMBINE, OUTPUT.
- ACCUM:
  - in_ready=1.
  - On transfer, issue add_valid=1 with add_a=in_data and add_b=current psum of lane ptr.
  - Push a tag {valid, lane} into a tag shift register ADD_LATENCY deep.
  - ptr advances modulo ADD_LATENCY on transfer only. Idle cycles do not rotate the lane.
  - Bypass: if add_result_valid and the returning tag lane == ptr in the same cycle, add_b = add_result, not the stored psum.
  - On transfer with in_last=1: go to DRAIN and drop in_ready next cycle.
- Writeback: when add_result_valid and the emerging tag is valid, write add_result to psum[tag.lane]. If the emerging tag is invalid, add_result_valid is ignored; this covers stale adder outputs after reset.
- DRAIN:
  - in_ready=0.
  - Wait until the tag pipeline is empty, including the writeback cycle.
  - Then go to COMBINE with acc=psum[0] and k=1.
- COMBINE:
  - For k=1..ADD_LATENCY-1: issue add(acc, psum[k]), wait for the result, latch acc, then the next k issues the following cycle.
  - If ADD_LATENCY=1: skip directly to OUTPUT with out_data=psum[0].
- OUTPUT:
  - out_valid=1, out_data=acc.
  - On transfer: clear all psum to 0, ptr=0, return to ACCUM. in_ready=1 the next cycle.
- Latency: out_valid rises ADD_LATENCY²+ADD_LATENCY cycles after the cycle the last word is accepted (6 for ADD_LATENCY=2).
- Single-word packet: unused lanes remain 0, so the sum equals x through the adder.
- Arithmetic: all rounding and normalisation come from the attached adder. The block does no arithmetic of its own.
- Reset mid-packet: partial sums are discarded and no output is produced. The next accepted word starts a new packet.

Optional Feature:
FP_ACC_COUNT_EN
- Defined:
  - Adds output out_count [15:0], the number of words in the packet, valid with out_valid.
  - The counter saturates at 16'hFFFF, resets to 0, and clears on output transfer.
- Undefined: no port, no counter logic.

Decomposition:
- Package fp_pkg holds:
  - FP_ZERO constant.
  - acc_state_t enum (ACCUM, DRAIN, COMBINE, OUTPUT).
  - lane tag struct {valid, lane}.
- Sub-module fp_tag_pipe: parameterised ADD_LATENCY-deep shift register of tags, with async reset and an empty flag.
- fp_add is instantiated by the parent/bench, not inside this block.

Test Plan:
(Bench uses fp_add with EXP=8, MANT=7, ADD_LATENCY=2. Last word accepted at cycle t.)
1. Packet 0x3F80,0x4000,0x4040,0x4080 (1,2,3,4), back-to-back, in_last on 4th -> out_data=0x4120 (10.0); out_valid at t+6; in_ready=0 from t+1 until the output transfer.
2. Single word 0x4040 with in_last -> out_data=0x4040.
3. Same packet as scenario 1 with one-cycle in_valid gaps -> out_data=0x4120 (lane rotation on transfer only, bypass/storage correct).
4. out_ready held low 5 cycles after out_valid -> out_data stable at 0x4120; one transfer; in_ready returns next cycle.
5. Assert clock_sreset asynchronously after 2 words of a packet, then send 0x3F80 with last -> out_data=0x3F80; stale add_result_valid ignored.
6. FP_ACC_COUNT_EN defined, scenario 1 packet -> out_count=4; second packet of 1 word -> out_count=1.
